// File: rtl/pattern_pkg.sv
// -----------------------------------------------------------------------------
// pattern_pkg
// Shared constants and types for the "2-5-3" pattern reader.
//   - SEG_* : active-low seven-segment images (bit 0 = a ... bit 6 = g)
//   - CODE_*: 2-bit character codes carried on code2..code0
//   - PHASE_NONE: phase value reported when no valid rotation is held
//   - state_e: acceptance FSM states
// -----------------------------------------------------------------------------
package pattern_pkg;

   localparam int NUM_DIGITS = 3;

   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [1:0] CODE_2     = 2'b00;
   localparam logic [1:0] CODE_5     = 2'b01;
   localparam logic [1:0] CODE_3     = 2'b10;
   localparam logic [1:0] CODE_BLANK = 2'b11;

   localparam logic [1:0] PHASE_NONE = 2'd3;

   typedef enum logic [1:0] {
      ST_SETTLE = 2'd0,
      ST_LOCKED = 2'd1,
      ST_FAULT  = 2'd2
   } state_e;

   // Rotation phase of a legal (HEX2, HEX1, HEX0) code triple.
   function automatic logic [1:0] phase_of(input logic [1:0] c2,
                                           input logic [1:0] c1,
                                           input logic [1:0] c0);
      if (c2 == CODE_2 && c1 == CODE_5 && c0 == CODE_3) return 2'd0;
      if (c2 == CODE_5 && c1 == CODE_3 && c0 == CODE_2) return 2'd1;
      if (c2 == CODE_3 && c1 == CODE_2 && c0 == CODE_5) return 2'd2;
      return PHASE_NONE;
   endfunction

   // Forward successor of a phase in 0..2.
   function automatic logic [1:0] next_phase(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

endpackage

// File: rtl/seg7_to_char.sv
// -----------------------------------------------------------------------------
// seg7_to_char
// Combinational decode of one active-low seven-segment bus to a character.
//   seg   in  7  segment bus, bit 0 = a ... bit 6 = g
//   legal out 1  segment image is one of "2", "5", "3" or blank
//   code  out 2  character code; 11 for blank and for any illegal image
// -----------------------------------------------------------------------------
module seg7_to_char
   import pattern_pkg::*;
(
   input  logic [6:0] seg,
   output logic       legal,
   output logic [1:0] code
);

   always_comb begin
      legal = 1'b1;
      code  = CODE_BLANK;
      case (seg)
         SEG_2:     code = CODE_2;
         SEG_5:     code = CODE_5;
         SEG_3:     code = CODE_3;
         SEG_BLANK: code = CODE_BLANK;
         default: begin
            // Illegal images report blank so a fault load needs no extra mux.
            legal = 1'b0;
            code  = CODE_BLANK;
         end
      endcase
   end

endmodule

// File: rtl/hex_pattern_reader.sv
// -----------------------------------------------------------------------------
// hex_pattern_reader
// Monitors the HEX2..HEX0 nets of the rotating "2-5-3" display, waits for a
// pattern to hold for STABLE_CYCLES cycles, then reports its character codes
// and rotation phase, flags illegal segment images and counts forward steps.
//
// Parameters
//   STABLE_CYCLES  cycles (>= 2) a sampled pattern must hold before acceptance
//   CNT_W          width of rot_count
// Ports
//   CLOCK_50                 in   system clock, rising edge
//   reset                    in   synchronous active-high reset
//   HEX2, HEX1, HEX0         in   active-low segment buses (bit 0 = a)
//   code2, code1, code0      out  accepted character codes
//   phase                    out  accepted phase 0..2, 3 = no valid rotation
//   valid                    out  accepted error-free pattern held
//   err                      out  accepted pattern has an illegal digit
//   phase_change             out  one-cycle pulse on a change of accepted phase
//   rot_count                out  forward-rotation counter
// Configuration
//   PATTERN_READER_ROTCNT_EN  defined: rot_count is built; undefined: tied to 0
// -----------------------------------------------------------------------------
module hex_pattern_reader
   import pattern_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic [6:0]       HEX2,
   input  logic [6:0]       HEX1,
   input  logic [6:0]       HEX0,
   output logic [1:0]       code2,
   output logic [1:0]       code1,
   output logic [1:0]       code0,
   output logic [1:0]       phase,
   output logic             valid,
   output logic             err,
   output logic             phase_change,
   output logic [CNT_W-1:0] rot_count
);

   localparam int                STAB_W   = $clog2(STABLE_CYCLES);
   localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);

   logic [NUM_DIGITS-1:0][6:0] hex_d, hex_q;
   state_e                     state_d, state_q;
   logic [STAB_W-1:0]          stab_cnt_d, stab_cnt_q;
   logic [NUM_DIGITS-1:0][1:0] code_d, code_q;
   logic [1:0]                 phase_d, phase_q;
   logic                       valid_d, valid_q;
   logic                       err_d, err_q;
   logic                       phase_change_d, phase_change_q;

   logic [NUM_DIGITS-1:0]      dig_legal;
   logic [NUM_DIGITS-1:0][1:0] dig_code;
   logic                       hex_chg;
   logic                       all_legal;
   logic                       accept;
   logic [1:0]                 new_phase;

   assign hex_d = {HEX2, HEX1, HEX0};

   // Decode the registered sample, one decoder per digit.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
         seg7_to_char u_dec (
            .seg   (hex_q[gi]),
            .legal (dig_legal[gi]),
            .code  (dig_code[gi])
         );
      end
   endgenerate

   // hex_chg is true on the edge where hex_q takes a new value.
   assign hex_chg   = (hex_d != hex_q);
   assign all_legal = &dig_legal;
   assign new_phase = all_legal ? phase_of(dig_code[2], dig_code[1], dig_code[0])
                                : PHASE_NONE;
   // A change arriving on the threshold edge wins: no acceptance that cycle.
   assign accept    = (state_q == ST_SETTLE) && (stab_cnt_q == STAB_MAX) && !hex_chg;

   always_comb begin
      state_d        = state_q;
      code_d         = code_q;
      phase_d        = phase_q;
      valid_d        = valid_q;
      err_d          = err_q;
      phase_change_d = 1'b0;

      if (hex_chg)                    stab_cnt_d = '0;
      else if (stab_cnt_q == STAB_MAX) stab_cnt_d = stab_cnt_q;
      else                            stab_cnt_d = stab_cnt_q + STAB_W'(1);

      unique case (state_q)
         ST_SETTLE: begin
            if (accept) begin
               // Illegal digits already decode to 11, so codes load as-is.
               code_d         = dig_code;
               phase_d        = new_phase;
               phase_change_d = (new_phase != phase_q);
               if (all_legal) begin
                  state_d = ST_LOCKED;
                  valid_d = 1'b1;
                  err_d   = 1'b0;
               end else begin
                  state_d = ST_FAULT;
                  valid_d = 1'b0;
                  err_d   = 1'b1;
               end
            end
         end
         ST_LOCKED, ST_FAULT: begin
            if (hex_chg) begin
               state_d = ST_SETTLE;
               valid_d = 1'b0;
               err_d   = 1'b0;
            end
         end
         default: begin
            state_d = ST_SETTLE;
            valid_d = 1'b0;
            err_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         hex_q          <= '1;
         state_q        <= ST_SETTLE;
         stab_cnt_q     <= '0;
         code_q         <= {NUM_DIGITS{CODE_BLANK}};
         phase_q        <= PHASE_NONE;
         valid_q        <= 1'b0;
         err_q          <= 1'b0;
         phase_change_q <= 1'b0;
      end else begin
         hex_q          <= hex_d;
         state_q        <= state_d;
         stab_cnt_q     <= stab_cnt_d;
         code_q         <= code_d;
         phase_q        <= phase_d;
         valid_q        <= valid_d;
         err_q          <= err_d;
         phase_change_q <= phase_change_d;
      end
   end

`ifdef PATTERN_READER_ROTCNT_EN
   // phase_q doubles as the last-accepted-phase register: a FAULT acceptance
   // forces it to 3, so a non-3 value always is the previous LOCKED phase
   // with no FAULT in between.
   logic [CNT_W-1:0] rot_count_d, rot_count_q;
   logic             rot_step;

   assign rot_step = accept && all_legal && (phase_q != PHASE_NONE) &&
                     (new_phase == next_phase(phase_q));

   always_comb begin
      rot_count_d = rot_count_q;
      if (rot_step) rot_count_d = rot_count_q + CNT_W'(1);
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) rot_count_q <= '0;
      else       rot_count_q <= rot_count_d;
   end

   assign rot_count = rot_count_q;
`else
   assign rot_count = '0;
`endif

   assign code2        = code_q[2];
   assign code1        = code_q[1];
   assign code0        = code_q[0];
   assign phase        = phase_q;
   assign valid        = valid_q;
   assign err          = err_q;
   assign phase_change = phase_change_q;

endmodule

// File: tb/tb_hex_pattern_reader.sv
// -----------------------------------------------------------------------------
// tb_hex_pattern_reader
// Directed scenarios plus randomized hold lengths, every cycle compared against
// a run-length reference model of the reader.
// -----------------------------------------------------------------------------
module tb_hex_pattern_reader;

   localparam int S  = 4;
   localparam int CW = 8;

   localparam logic [6:0]  C2 = 7'b0100100;
   localparam logic [6:0]  C5 = 7'b0010010;
   localparam logic [6:0]  C3 = 7'b0110000;
   localparam logic [6:0]  CB = 7'b1111111;
   localparam logic [20:0] P0 = {C2, C5, C3};
   localparam logic [20:0] P1 = {C5, C3, C2};
   localparam logic [20:0] P2 = {C3, C2, C5};
   localparam logic [20:0] PB = {CB, CB, CB};
   localparam logic [18:0] RST_VEC = {2'b11, 2'b11, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 8'd0};

   logic          CLOCK_50 = 1'b0;
   logic          reset    = 1'b1;
   logic [6:0]    HEX2 = CB, HEX1 = CB, HEX0 = CB;
   logic [1:0]    code2, code1, code0, phase;
   logic          valid, err, phase_change;
   logic [CW-1:0] rot_count;

   int n_cmp = 0;
   int n_bad = 0;

   always #10 CLOCK_50 = ~CLOCK_50;

   hex_pattern_reader #(.STABLE_CYCLES(S), .CNT_W(CW)) dut (
      .CLOCK_50     (CLOCK_50),
      .reset        (reset),
      .HEX2         (HEX2),
      .HEX1         (HEX1),
      .HEX0         (HEX0),
      .code2        (code2),
      .code1        (code1),
      .code0        (code0),
      .phase        (phase),
      .valid        (valid),
      .err          (err),
      .phase_change (phase_change),
      .rot_count    (rot_count)
   );

   logic [18:0] dut_vec;
   assign dut_vec = {code2, code1, code0, phase, valid, err, phase_change, rot_count};

   // ---------------- reference model ----------------
   // A value is accepted on the edge where it has been sampled S+1 times in a
   // row; the reset edge counts as one sample of all-ones.
   logic [20:0]     m_prev;
   int              m_run;
   logic [2:0][1:0] m_code;
   int              m_phase;
   int              m_lock;     // phase of last LOCKED acceptance, 3 if none / fault since
   logic            m_valid, m_err, m_pc;
   logic [CW-1:0]   m_cnt;

   function automatic logic [2:0] char_of(input logic [6:0] s);
      logic [6:0] tbl [4];
      tbl = '{C2, C5, C3, CB};
      for (int i = 0; i < 4; i++)
         if (s == tbl[i]) return {1'b1, 2'(i)};
      return 3'b011;
   endfunction

   function automatic logic [6:0] rand_char();
      case ($urandom_range(0, 3))
         0:       return C2;
         1:       return C5;
         2:       return C3;
         default: return CB;
      endcase
   endfunction

   function automatic logic [18:0] exp_vec();
      return {m_code, 2'(m_phase), m_valid, m_err, m_pc, m_cnt};
   endfunction

   task automatic m_reset();
      m_prev = '1; m_run = 1;
      m_code = '1; m_phase = 3; m_lock = 3;
      m_valid = 0; m_err = 0; m_pc = 0; m_cnt = '0;
   endtask

   task automatic m_edge(input logic [20:0] v);
      logic [2:0] ch;
      logic       legal;
      logic [2:0][1:0] c;
      int         newp;
      m_pc = 0;
      if (v == m_prev) m_run++;
      else begin m_run = 1; m_prev = v; end
      if (m_run == 1) begin
         m_valid = 0; m_err = 0;
      end else if (m_run == S + 1) begin
         legal = 1;
         for (int d = 0; d < 3; d++) begin
            ch = char_of(v[d*7 +: 7]);
            legal &= ch[2];
            c[d] = ch[1:0];
         end
         newp = 3;
         if (legal)
            for (int k = 0; k < 3; k++)
               if (c[2] == 2'((0 + k) % 3) && c[1] == 2'((1 + k) % 3) && c[0] == 2'((2 + k) % 3))
                  newp = k;
         m_pc = (newp != m_phase);
         if (legal) begin
            m_valid = 1; m_err = 0;
`ifdef PATTERN_READER_ROTCNT_EN
            if (m_lock != 3 && newp == (m_lock + 1) % 3) m_cnt = m_cnt + 1'b1;
`endif
            m_lock = newp;
         end else begin
            m_valid = 0; m_err = 1; m_lock = 3;
         end
         m_phase = newp;
         m_code  = c;
      end
      if (m_run > 1000) m_run = S + 2;
   endtask

   // Drive one cycle; the model advances on the same edge, outputs are read #1 later.
   task automatic cycle(input logic [20:0] v, input logic rst);
      {HEX2, HEX1, HEX0} = v;
      reset = rst;
      @(posedge CLOCK_50);
      if (rst) m_reset(); else m_edge(v);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         cycle(21'($urandom), 1'b1);
         n_cmp++;
         if (dut_vec !== RST_VEC) begin
            n_bad++; $display("FAIL reset_state: got %h want %h", dut_vec, RST_VEC);
         end
      end
   endtask

   task automatic test_first_lock();
      int first_valid = -1;
      for (int i = 1; i <= 12; i++) begin
         cycle(P0, 1'b0);
         if (valid === 1'b1 && first_valid < 0) first_valid = i;
         n_cmp++;
         if (dut_vec !== exp_vec()) begin
            n_bad++; $display("FAIL first_lock cyc%0d: got %h want %h", i, dut_vec, exp_vec());
         end
      end
      n_cmp++;
      if (first_valid != S + 1) begin
         n_bad++; $display("FAIL first_lock_latency: got %0d want %0d", first_valid, S + 1);
      end
   endtask

   task automatic test_rotation();
      logic [20:0] seq [3];
      int pulses = 0;
      logic [CW-1:0] want;
      seq = '{P1, P2, P0};
      for (int s = 0; s < 3; s++)
         for (int i = 0; i < 10; i++) begin
            cycle(seq[s], 1'b0);
            pulses += int'(phase_change === 1'b1);
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
               n_bad++; $display("FAIL rotation step%0d: got %h want %h", s, dut_vec, exp_vec());
            end
         end
`ifdef PATTERN_READER_ROTCNT_EN
      want = 8'd3;
`else
      want = 8'd0;
`endif
      n_cmp++;
      if (pulses != 3) begin
         n_bad++; $display("FAIL rotation_pulses: got %0d want 3", pulses);
      end
      n_cmp++;
      if (rot_count !== want) begin
         n_bad++; $display("FAIL rotation_count: got %0d want %0d", rot_count, want);
      end
      for (int i = 0; i < 10; i++) begin
         cycle(P2, 1'b0);
         n_cmp++;
         if (dut_vec !== exp_vec()) begin
            n_bad++; $display("FAIL skip_step: got %h want %h", dut_vec, exp_vec());
         end
      end
      n_cmp++;
      if (rot_count !== want || phase !== 2'd2) begin
         n_bad++; $display("FAIL skip_count: got cnt %0d ph %0d want cnt %0d ph 2", rot_count, phase, want);
      end
      for (int i = 0; i < 10; i++) cycle(P0, 1'b0);
   endtask

   task automatic test_fault();
      logic [CW-1:0] cnt0;
      cnt0 = rot_count;
      for (int i = 0; i < 10; i++) begin
         cycle({C2, C5, 7'b0000000}, 1'b0);
         n_cmp++;
         if (dut_vec !== exp_vec()) begin
            n_bad++; $display("FAIL fault cyc%0d: got %h want %h", i, dut_vec, exp_vec());
         end
      end
      n_cmp++;
      if ({err, valid, phase, code0} !== {1'b1, 1'b0, 2'd3, 2'b11}) begin
         n_bad++; $display("FAIL fault_flags: got err%b val%b ph%0d c0 %b want err1 val0 ph3 c0 11",
                           err, valid, phase, code0);
      end
      for (int i = 0; i < 10; i++) begin
         cycle(P0, 1'b0);
         n_cmp++;
         if (dut_vec !== exp_vec()) begin
            n_bad++; $display("FAIL fault_recover cyc%0d: got %h want %h", i, dut_vec, exp_vec());
         end
      end
      n_cmp++;
      if ({valid, err, rot_count} !== {1'b1, 1'b0, cnt0}) begin
         n_bad++; $display("FAIL fault_reentry: got val%b err%b cnt%0d want val1 err0 cnt%0d",
                           valid, err, rot_count, cnt0);
      end
   endtask

   task automatic test_glitch();
      int low = 0, pulses = 0;
      logic [CW-1:0] cnt0;
      cnt0 = rot_count;
      for (int i = 0; i < 14; i++) begin
         cycle((i < 2) ? {C2, C3, C3} : P0, 1'b0);
         low    += int'(valid === 1'b0);
         pulses += int'(phase_change === 1'b1);
         n_cmp++;
         if (dut_vec !== exp_vec()) begin
            n_bad++; $display("FAIL glitch cyc%0d: got %h want %h", i, dut_vec, exp_vec());
         end
      end
      n_cmp++;
      if (low != S + 2 || pulses != 0 || rot_count !== cnt0 || phase !== 2'd0) begin
         n_bad++; $display("FAIL glitch_summary: got low%0d pc%0d cnt%0d ph%0d want low%0d pc0 cnt%0d ph0",
                           low, pulses, rot_count, phase, S + 2, cnt0);
      end
   endtask

   task automatic test_blank_and_reset();
      for (int i = 0; i < 10; i++) begin
         cycle(PB, 1'b0);
         n_cmp++;
         if (dut_vec !== exp_vec()) begin
            n_bad++; $display("FAIL blank cyc%0d: got %h want %h", i, dut_vec, exp_vec());
         end
      end
      n_cmp++;
      if ({valid, phase, code2, code1, code0} !== {1'b1, 2'd3, 6'b111111}) begin
         n_bad++; $display("FAIL blank_flags: got val%b ph%0d codes %b%b%b want val1 ph3 codes 111111",
                           valid, phase, code2, code1, code0);
      end
      cycle(P1, 1'b0);
      cycle(P1, 1'b0);
      cycle(P1, 1'b1);
      n_cmp++;
      if (dut_vec !== RST_VEC) begin
         n_bad++; $display("FAIL reset_mid_settle: got %h want %h", dut_vec, RST_VEC);
      end
      for (int i = 0; i < 8; i++) begin
         cycle(P1, 1'b0);
         n_cmp++;
         if (dut_vec !== exp_vec()) begin
            n_bad++; $display("FAIL post_reset cyc%0d: got %h want %h", i, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_random();
      logic [20:0] v;
      int hold, kind;
      v = P1;
      for (int s = 0; s < 150; s++) begin
         kind = $urandom_range(0, 7);
         case (kind)
            0: v = P0;
            1: v = P1;
            2: v = P2;
            3: v = {rand_char(), rand_char(), rand_char()};
            4: v = 21'($urandom);
            5: v[7*$urandom_range(0, 2) +: 7] = rand_char();
            default: ;
         endcase
         hold = $urandom_range(1, S + 3);
         for (int h = 0; h < hold; h++) begin
            cycle(v, (kind == 7 && h == 0) ? 1'b1 : 1'b0);
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
               n_bad++; $display("FAIL random seg%0d cyc%0d in %h: got %h want %h",
                                 s, h, v, dut_vec, exp_vec());
            end
         end
      end
   endtask

   initial begin
      m_reset();
      test_reset();
      test_first_lock();
      test_rotation();
      test_fault();
      test_glitch();
      test_blank_and_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
